// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Byte FIFO plus launch sequencer feeding UART_TX via tx_en/tx_state.
// Revision : 1.0
// ============================================================================
module uart_tx_scheduler #(
    parameter int DEPTH        = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               tx_data,
    output logic                     tx_en,
    input  logic                     tx_state,
    output logic                     done_irq,
    output logic                     ovf_err,
    output logic                     tmo_err
);
    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int c_CW      = $clog2(c_CNT_MAX) + 1;
    localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(DEPTH);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(BUSY_TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST = c_CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [7:0]      r_tx_data;
    logic            r_ovf_err;
    logic            r_tmo_err;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_set;
    logic            w_tmo_set;
    logic            w_done;

    assign fifo_full  = (r_count == c_FULL);
    assign fifo_empty = (r_count == '0);
    assign fifo_count = r_count;
    assign tx_data    = r_tx_data;
    assign ovf_err    = r_ovf_err;
    assign tmo_err    = r_tmo_err;
    assign done_irq   = w_done;

    // flush outranks a same-cycle write and suppresses its overflow report
    assign w_push    = wr_en & ~fifo_full & ~flush;
    assign w_ovf_set = wr_en &  fifo_full & ~flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tx_data <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
                r_count <= r_count + {c_AW'(0), w_push} - {c_AW'(0), w_pop};
            end
            // the in-flight byte survives a flush that lands on its launch edge
            if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_ovf_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            if (w_ovf_set)    r_ovf_err <= 1'b1;
            else if (err_clr) r_ovf_err <= 1'b0;
            if (w_tmo_set)    r_tmo_err <= 1'b1;
            else if (err_clr) r_tmo_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_tmo_set   = 1'b0;
        w_done      = 1'b0;
        tx_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty && !tx_state) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_en       = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_state) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_tmo_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_state) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    w_done      = fifo_empty & ~w_push;
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) w_state_nxt = S_IDLE;
                else                     w_cnt_nxt   = r_cnt + c_CW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
